instr_fetch_ctrl: RTL and testbench

- Control unit at the far end of the program-counter interface. It drives the PC increment and clear strobes and consumes the instruction word addressed by the PC.
- It latches that word into an instruction register (IR), decodes the opcode and sequences the datapath: data memory, register file and ALU.
- Sits between the PC counter plus instruction ROM on one side and the datapath on the other.

---
 rtl/instr_fetch_ctrl_pkg.sv | 48 ++++
 rtl/instr_fetch_ctrl_instr_reg.sv | 24 ++
 rtl/instr_fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_instr_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch/decode controller:
// opcode and state encodings, datapath widths and ALU select codes.
package proc_pkg;

  localparam int IW  = 16;
  localparam int DAW = 8;
  localparam int RAW = 4;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_t;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    IDLE   = 4'd1,
    FETCH  = 4'd2,
    DECODE = 4'd3,
    NOOP   = 4'd4,
    LOAD_A = 4'd5,
    LOAD_B = 4'd6,
    STORE  = 4'd7,
    ADD    = 4'd8,
    SUB    = 4'd9,
    HALT   = 4'd10
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  // Unused opcode values collapse onto NOOP.
  function automatic opcode_t decode_op(input logic [3:0] op);
    case (op)
      4'h1:    return OP_STORE;
      4'h2:    return OP_LOAD;
      4'h3:    return OP_ADD;
      4'h4:    return OP_SUB;
      4'h5:    return OP_HALT;
      default: return OP_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_instr_reg.sv
// Instruction register: W-bit storage with load enable and a synchronous
// active-low clear that overrides the load.
module instr_reg #(
  parameter int W = proc_pkg::IW
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear has priority; otherwise capture d when load is high.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      q <= {W{1'b0}};
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch/decode/execute sequencer between the PC + instruction ROM and the datapath.
// Optional SINGLE_STEP_EN: each execute state returns to IDLE, one instruction per run.
module instr_fetch_ctrl #(
  parameter int IW  = proc_pkg::IW,
  parameter int DAW = proc_pkg::DAW,
  parameter int RAW = proc_pkg::RAW
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           run,
  input  logic [IW-1:0]  im_data,
  output logic           pc_up,
  output logic           pc_clr,
  output logic [IW-1:0]  ir,
  output logic [DAW-1:0] d_addr,
  output logic           d_wr,
  output logic           rf_s,
  output logic [RAW-1:0] rf_w_addr,
  output logic           rf_w_wr,
  output logic [RAW-1:0] rf_ra_addr,
  output logic           rf_ra_rd,
  output logic [RAW-1:0] rf_rb_addr,
  output logic           rf_rb_rd,
  output logic [2:0]     alu_sel,
  output logic           instr_done,
  output logic           halted
);
  import proc_pkg::*;

`ifdef SINGLE_STEP_EN
  localparam state_t EXEC_NEXT = IDLE;
`else
  localparam state_t EXEC_NEXT = FETCH;
`endif

  state_t state_r;
  state_t next_state_s;

  // ir captures the ROM word during FETCH, so it is valid from DECODE onwards.
  instr_reg #(.W(IW)) u_instr_reg (
    .clk   (clk),
    .clr_n (reset_n),
    .load  (state_r == FETCH),
    .d     (im_data),
    .q     (ir)
  );

  // State register; reset wins from any state, including mid-instruction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= INIT;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      INIT:   next_state_s = IDLE;
      IDLE: begin
        if (run) begin
          next_state_s = FETCH;
        end else begin
          next_state_s = IDLE;
        end
      end
      FETCH:  next_state_s = DECODE;
      DECODE: begin
        case (decode_op(ir[IW-1 -: 4]))
          OP_STORE: next_state_s = STORE;
          OP_LOAD:  next_state_s = LOAD_A;
          OP_ADD:   next_state_s = ADD;
          OP_SUB:   next_state_s = SUB;
          OP_HALT:  next_state_s = HALT;
          default:  next_state_s = NOOP;
        endcase
      end
      LOAD_A: next_state_s = LOAD_B;
      NOOP, LOAD_B, STORE, ADD, SUB: next_state_s = EXEC_NEXT;
      HALT:   next_state_s = HALT;
      default: next_state_s = INIT;
    endcase
  end

  // Moore output decode from state and ir.
  always_comb begin
    pc_up      = 1'b0;
    pc_clr     = 1'b0;
    d_addr     = {DAW{1'b0}};
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = {RAW{1'b0}};
    rf_w_wr    = 1'b0;
    rf_ra_addr = {RAW{1'b0}};
    rf_ra_rd   = 1'b0;
    rf_rb_addr = {RAW{1'b0}};
    rf_rb_rd   = 1'b0;
    alu_sel    = ALU_PASS;
    instr_done = 1'b0;
    halted     = 1'b0;
    case (state_r)
      INIT:  pc_clr = 1'b1;
      FETCH: pc_up  = 1'b1;
      NOOP:  instr_done = 1'b1;
      LOAD_A: begin
        d_addr    = ir[4 +: DAW];
        rf_s      = 1'b1;
        rf_w_addr = ir[0 +: RAW];
      end
      LOAD_B: begin
        d_addr     = ir[4 +: DAW];
        rf_s       = 1'b1;
        rf_w_addr  = ir[0 +: RAW];
        rf_w_wr    = 1'b1;
        instr_done = 1'b1;
      end
      STORE: begin
        d_addr     = ir[4 +: DAW];
        d_wr       = 1'b1;
        rf_ra_addr = ir[0 +: RAW];
        rf_ra_rd   = 1'b1;
        instr_done = 1'b1;
      end
      ADD, SUB: begin
        rf_ra_addr = ir[8 +: RAW];
        rf_rb_addr = ir[4 +: RAW];
        rf_ra_rd   = 1'b1;
        rf_rb_rd   = 1'b1;
        rf_w_addr  = ir[0 +: RAW];
        rf_w_wr    = 1'b1;
        alu_sel    = (state_r == ADD) ? ALU_ADD : ALU_SUB;
        instr_done = 1'b1;
      end
      HALT:  halted = 1'b1;
      default: halted = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: PC counter + synchronous ROM model around
// the DUT, and an instruction-level reference model producing per-cycle expected outputs.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [15:0] im_data = 16'h0000;
  logic        pc_up, pc_clr, d_wr, rf_s, rf_w_wr, rf_ra_rd, rf_rb_rd, instr_done, halted;
  logic [15:0] ir;
  logic [7:0]  d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
  logic [2:0]  alu_sel;

  instr_fetch_ctrl dut (
    .clk(clk), .reset_n(reset_n), .run(run), .im_data(im_data),
    .pc_up(pc_up), .pc_clr(pc_clr), .ir(ir), .d_addr(d_addr), .d_wr(d_wr),
    .rf_s(rf_s), .rf_w_addr(rf_w_addr), .rf_w_wr(rf_w_wr),
    .rf_ra_addr(rf_ra_addr), .rf_ra_rd(rf_ra_rd),
    .rf_rb_addr(rf_rb_addr), .rf_rb_rd(rf_rb_rd),
    .alu_sel(alu_sel), .instr_done(instr_done), .halted(halted)
  );

  always #5 clk = ~clk;

  // Environment: 7-bit PC (wraps 127->0) and 1-cycle-latency ROM addressed by it.
  logic [15:0] rom [0:127];
  logic [6:0]  pc = 7'd0;
  always @(posedge clk) begin
    if (pc_clr) pc <= 7'd0;
    else if (pc_up) pc <= pc + 7'd1;
    im_data <= rom[pc];
  end

  logic [47:0] obs;
  assign obs = {ir, pc_up, pc_clr, d_addr, d_wr, rf_s, rf_w_addr, rf_w_wr,
                rf_ra_addr, rf_ra_rd, rf_rb_addr, rf_rb_rd, alu_sel, instr_done, halted};

  int          n_checks = 0;
  int          n_pass = 0;
  logic [47:0] exp_q [$];
  logic [15:0] model_ir = 16'h0000;

  function automatic logic [47:0] vec(
    input logic [15:0] ir_v, input logic up, input logic clr,
    input logic [7:0] da, input logic dw, input logic rs,
    input logic [3:0] wa, input logic ww,
    input logic [3:0] ra, input logic rr, input logic [3:0] rb, input logic br,
    input logic [2:0] alu, input logic done, input logic hlt);
    return {ir_v, up, clr, da, dw, rs, wa, ww, ra, rr, rb, br, alu, done, hlt};
  endfunction

  function automatic logic [47:0] quiet(input logic [15:0] ir_v);
    return vec(ir_v, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);
  endfunction

  // Reference model: cycle-by-cycle outputs of one instruction, from FETCH to its last cycle.
  function automatic void push_instr(input logic [15:0] w);
    exp_q.push_back(vec(model_ir, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0));
    model_ir = w;
    exp_q.push_back(quiet(w));
    case (w[15:12])
      4'h1: exp_q.push_back(vec(w, 1'b0, 1'b0, w[11:4], 1'b1, 1'b0, 4'h0, 1'b0, w[3:0], 1'b1, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0));
      4'h2: begin
        exp_q.push_back(vec(w, 1'b0, 1'b0, w[11:4], 1'b0, 1'b1, w[3:0], 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0));
        exp_q.push_back(vec(w, 1'b0, 1'b0, w[11:4], 1'b0, 1'b1, w[3:0], 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0));
      end
      4'h3: exp_q.push_back(vec(w, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, w[3:0], 1'b1, w[11:8], 1'b1, w[7:4], 1'b1, 3'b001, 1'b1, 1'b0));
      4'h4: exp_q.push_back(vec(w, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, w[3:0], 1'b1, w[11:8], 1'b1, w[7:4], 1'b1, 3'b010, 1'b1, 1'b0));
      4'h5: exp_q.push_back(vec(w, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b1));
      default: exp_q.push_back(vec(w, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0));
    endcase
  endfunction

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    w[15:12] = 4'($urandom_range(0, 7));
    if (w[15:12] == 4'h5) w[15:12] = 4'h3;
    return w;
  endfunction

  // Leaves the DUT in IDLE with PC=0, ready for run=1 at the current negedge.
  task automatic apply_reset();
    reset_n = 1'b0;
    run = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    model_ir = 16'h0000;
  endtask

  task automatic test_reset();
    run = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== vec(16'h0000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0))
      $display("FAIL reset_init: got %h want pc_clr only", obs);
    else n_pass++;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== quiet(16'h0000)) $display("FAIL reset_idle[%0d]: got %h want all zero", i, obs);
      else n_pass++;
    end
    run = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== vec(16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0))
      $display("FAIL reset_first_fetch: got %h want pc_up only", obs);
    else n_pass++;
    run = 1'b0;
  endtask

  task automatic test_directed_program();
    logic [47:0] exp_v;
    int cyc = 0;
    for (int i = 0; i < 128; i++) rom[i] = 16'h5000;
    rom[0] = 16'h21B3; rom[1] = 16'h3125; rom[2] = 16'h4125;
    rom[3] = 16'h1A57; rom[4] = 16'hF123; rom[5] = 16'h5000;
    apply_reset();
    run = 1'b1;
    for (int k = 0; k < 6; k++) push_instr(rom[k]);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) $display("FAIL directed cyc %0d: got %h want %h", cyc, obs, exp_v);
      else n_pass++;
      run = 1'($urandom_range(0, 1));
      cyc++;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== vec(16'h5000, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b1))
        $display("FAIL halt_hold[%0d]: got %h want halted only", i, obs);
      else n_pass++;
      run = ~run;
    end
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (obs !== vec(16'h0000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0))
      $display("FAIL halt_reset: got %h want INIT outputs", obs);
    else n_pass++;
    reset_n = 1'b1;
    run = 1'b0;
  endtask

  task automatic test_reset_mid_load();
    logic [47:0] exp_v;
    int cyc = 0;
    rom[0] = 16'h21B3;
    apply_reset();
    run = 1'b1;
    push_instr(rom[0]);
    void'(exp_q.pop_back());
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) $display("FAIL midload cyc %0d: got %h want %h", cyc, obs, exp_v);
      else n_pass++;
      cyc++;
    end
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== vec(16'h0000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0))
        $display("FAIL midload_reset[%0d]: got %h want INIT outputs", i, obs);
      else n_pass++;
    end
    reset_n = 1'b1;
    run = 1'b0;
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    logic [47:0] exp_v;
    int cyc = 0;
    for (int i = 0; i < 128; i++) rom[i] = rand_instr();
    apply_reset();
    for (int k = 0; k < 10; k++) begin
      run = 1'b1;
      push_instr(rom[k]);
      while (exp_q.size() > 0) begin
        exp_v = exp_q.pop_front();
        @(negedge clk);
        n_checks++;
        if (obs !== exp_v) $display("FAIL step cyc %0d: got %h want %h", cyc, obs, exp_v);
        else n_pass++;
        run = 1'b0;
        cyc++;
      end
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        n_checks++;
        if (obs !== quiet(model_ir)) $display("FAIL step_idle %0d: got %h want %h", k, obs, quiet(model_ir));
        else n_pass++;
      end
    end
  endtask
`else
  task automatic test_random_wrap();
    logic [47:0] exp_v;
    int cyc = 0;
    for (int i = 0; i < 128; i++) rom[i] = rand_instr();
    apply_reset();
    run = 1'b1;
    for (int k = 0; k < 150; k++) push_instr(rom[k % 128]);
    while (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      @(negedge clk);
      n_checks++;
      if (obs !== exp_v) $display("FAIL random cyc %0d: got %h want %h", cyc, obs, exp_v);
      else n_pass++;
      run = 1'($urandom_range(0, 1));
      cyc++;
    end
    run = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    test_reset();
`ifdef SINGLE_STEP_EN
    test_single_step();
`else
    test_directed_program();
    test_reset_mid_load();
    test_random_wrap();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
